pixel_plot_sink: RTL

PIXEL_PLOT_SINK -- requirements
Module: pixel_plot_sink

---
 rtl/pixel_plot_sink.sv | 109 ++++++++++
 1 files changed

// File: rtl/pixel_plot_sink.sv
// rtl/pixel_plot_sink.sv - buffered pixel plot requests drained to a framebuffer write port
// Optional PLOT_CLIP_EN: discard requests outside the 160x120 screen.
module pixel_plot_sink #(
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [7:0]  x,
    input  logic [6:0]  y,
    input  logic [23:0] colour,
    input  logic        plot,
    input  logic        mem_ready,
    input  logic        overflow_clr,
    output logic [14:0] mem_addr,
    output logic [8:0]  mem_data,
    output logic        mem_wren,
    output logic [4:0]  fifo_count,
    output logic        busy,
    output logic        overflow
);
    typedef enum logic {S_IDLE, S_WRITE} state_t;

    localparam int         AW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [4:0] DEPTH_C = 5'(FIFO_DEPTH);

    state_t          state_q, state_d;
    logic [AW-1:0]   wptr_q, wptr_d, rptr_q, rptr_d;
    logic [4:0]      count_q, count_d;
    logic            overflow_q, overflow_d;
    logic [23:0]     fifo_q [FIFO_DEPTH];
    logic [23:0]     fifo_d [FIFO_DEPTH];

    logic            in_range, full, pop, push, drop;
    logic [14:0]     addr_calc;
    logic [23:0]     entry, head;

`ifdef PLOT_CLIP_EN
    assign in_range = (x < 8'd160) && (y < 7'd120);
`else
    assign in_range = 1'b1;
`endif

    // Entry packs {address[14:0], rgb333[8:0]} so the head drives both outputs directly.
    assign addr_calc = ({8'd0, y} * 15'd160) + {7'd0, x};
    assign entry     = {addr_calc, colour[23:21], colour[15:13], colour[7:5]};
    assign head      = fifo_q[rptr_q];
    assign full      = (count_q == DEPTH_C);
    assign pop       = (state_q == S_WRITE) && mem_ready;
    assign push      = plot && in_range && (!full || pop);
    assign drop      = plot && in_range && full && !pop;

    always_comb begin
        state_d    = state_q;
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        fifo_d     = fifo_q;

        if (push) begin
            fifo_d[wptr_q] = entry;
            wptr_d         = wptr_q + 1'b1;
        end
        if (pop) begin
            rptr_d = rptr_q + 1'b1;
        end
        count_d = count_q + {4'd0, push} - {4'd0, pop};

        if (drop) begin
            overflow_d = 1'b1;
        end else if (overflow_clr) begin
            overflow_d = 1'b0;
        end

        // IDLE waits one edge after the first push; WRITE keeps streaming while entries remain.
        case (state_q)
            S_IDLE:  state_d = (count_q != 5'd0) ? S_WRITE : S_IDLE;
            S_WRITE: state_d = (count_d != 5'd0) ? S_WRITE : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= 5'd0;
            overflow_q <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_q[i] <= 24'd0;
            end
        end else begin
            state_q    <= state_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            fifo_q     <= fifo_d;
        end
    end

    assign mem_wren   = (state_q == S_WRITE);
    assign mem_addr   = mem_wren ? head[23:9] : 15'd0;
    assign mem_data   = mem_wren ? head[8:0]  : 9'd0;
    assign fifo_count = count_q;
    assign busy       = (count_q != 5'd0) || mem_wren;
    assign overflow   = overflow_q;
endmodule
